// File: rtl/softmax_norm_ctrl.sv
// softmax_norm_ctrl: the sequencer for the softmax normalisation step.
// It loads one row of ROW_LEN non-negative Q2.13 exponents and accumulates their sum. The sum
// saturates to the positive D_W range. Each element is then sent to an external divider with
// the row sum as divisor, and the quotients are streamed out over valid/ready.
// Optional feature: define SOFTMAX_DIV_TIMEOUT_EN to enable a watchdog. It aborts the row when
// the divider stalls for DIV_TIMEOUT cycles and pulses O_ERR. Without it O_ERR is tied low.
module softmax_norm_ctrl #(
  parameter int unsigned D_W         = 16,
  parameter int unsigned ROW_LEN     = 8,
  parameter int unsigned DIV_TIMEOUT = 64
) (
  input  logic           I_CLK,
  input  logic           I_RST_N,
  input  logic           I_VLD,
  input  logic [D_W-1:0] I_DATA,
  output logic           O_RDY,
  output logic           O_DIV_START,
  output logic [D_W-1:0] O_DIVIDEND,
  output logic [D_W-1:0] O_DIVISOR,
  input  logic [D_W-1:0] I_DIV_QUOTIENT,
  input  logic           I_DIV_OUT_VLD,
  output logic           O_VLD,
  output logic [D_W-1:0] O_DATA,
  output logic           O_LAST,
  input  logic           I_RDY,
  output logic           O_SAT,
  output logic           O_ERR
);

  localparam int unsigned IDX_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam int unsigned SUM_W = D_W + IDX_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_LEN - 1);
  localparam logic [SUM_W-1:0] SUM_MAX  = {{(IDX_W + 1){1'b0}}, {(D_W - 1){1'b1}}};

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [SUM_W-1:0] r_sum;
  logic [D_W-1:0]   r_buf [ROW_LEN];
  logic [D_W-1:0]   r_data;
  logic             r_rdy;
  logic             r_sat;

  logic             w_accept;
  logic             w_div_busy;
  logic             w_timeout;
  logic             w_sum_ovf;
  logic [D_W-1:0]   w_elem;
  logic [SUM_W-1:0] w_sum_add;
  logic [1:0]       w_state_nxt;

  assign w_accept   = I_VLD && r_rdy;
  // Negative exponents cannot occur legitimately; treat them as zero weight.
  assign w_elem     = I_DATA[D_W-1] ? {D_W{1'b0}} : I_DATA;
  // The first element of a row restarts the accumulation.
  assign w_sum_add  = ((r_state == S_IDLE) ? {SUM_W{1'b0}} : r_sum) + SUM_W'(w_elem);
  assign w_sum_ovf  = (w_sum_add > SUM_MAX);
  // A zero row sum bypasses the divider entirely.
  assign w_div_busy = (r_state == S_DIV) && (r_sum != {SUM_W{1'b0}});

`ifdef SOFTMAX_DIV_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(DIV_TIMEOUT + 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_err;

  assign w_timeout = w_div_busy && !I_DIV_OUT_VLD && (r_tmo_cnt == TMO_W'(DIV_TIMEOUT - 1));

  // Watchdog: count stalled cycles of the current division; pulse the error on abort.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_timeout;
      if (w_div_busy && !I_DIV_OUT_VLD && !w_timeout) begin
        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      end else begin
        r_tmo_cnt <= '0;
      end
    end
  end

  assign O_ERR = r_err;
`else
  assign w_timeout = 1'b0;
  assign O_ERR     = 1'b0;
`endif

  // Next-state decode for the row sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_LOAD;
      S_LOAD: if (w_accept && (r_idx == LAST_IDX)) w_state_nxt = S_DIV;
      S_DIV: begin
        if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end else if (!w_div_busy || I_DIV_OUT_VLD) begin
          w_state_nxt = S_OUT;
        end
      end
      S_OUT: if (I_RDY) w_state_nxt = (r_idx == LAST_IDX) ? S_IDLE : S_DIV;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Sequencer state, element index, row sum, saturation flag and output register.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_sum   <= '0;
      r_sat   <= 1'b0;
      r_rdy   <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Registered ready: it follows the state we are about to enter.
      r_rdy   <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_LOAD);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_idx <= IDX_W'(1);
            r_sum <= w_sum_add;
            r_sat <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            if (r_idx == LAST_IDX) begin
              r_idx <= '0;
              r_sum <= w_sum_ovf ? SUM_MAX : w_sum_add;
              r_sat <= w_sum_ovf;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
              r_sum <= w_sum_add;
            end
          end
        end
        S_DIV: begin
          if (w_timeout) begin
            r_idx <= '0;
          end else if (!w_div_busy) begin
            r_data <= '0;
          end else if (I_DIV_OUT_VLD) begin
            r_data <= I_DIV_QUOTIENT;
          end
        end
        S_OUT: begin
          if (I_RDY) r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Row buffer: clamped elements written at the load index.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      for (int i = 0; i < int'(ROW_LEN); i++) r_buf[i] <= '0;
    end else if (w_accept) begin
      r_buf[r_idx] <= w_elem;
    end
  end

  assign O_RDY       = r_rdy;
  assign O_DIV_START = w_div_busy;
  assign O_DIVIDEND  = w_div_busy ? r_buf[r_idx] : {D_W{1'b0}};
  assign O_DIVISOR   = w_div_busy ? r_sum[D_W-1:0] : {D_W{1'b0}};
  assign O_VLD       = (r_state == S_OUT);
  assign O_DATA      = O_VLD ? r_data : {D_W{1'b0}};
  assign O_LAST      = O_VLD && (r_idx == LAST_IDX);
  assign O_SAT       = r_sat;

endmodule

// File: tb/tb_softmax_norm_ctrl.sv
// Bench for softmax_norm_ctrl: directed and random rows are checked against a row-level
// reference model. A behavioural divider with a fixed latency answers the DUT's requests.
module tb_softmax_norm_ctrl;

  localparam int D_W     = 16;
  localparam int ROW_LEN = 8;
  localparam int DIV_LAT = 31;
  localparam int Q_FRAC  = 13;
  localparam int POS_MAX = 32767;

  logic           I_CLK = 1'b0;
  logic           I_RST_N = 1'b0;
  logic           I_VLD = 1'b0;
  logic [D_W-1:0] I_DATA = '0;
  logic           I_DIV_OUT_VLD = 1'b0;
  logic [D_W-1:0] I_DIV_QUOTIENT = '0;
  logic           I_RDY = 1'b0;
  logic           O_RDY, O_DIV_START, O_VLD, O_LAST, O_SAT, O_ERR;
  logic [D_W-1:0] O_DIVIDEND, O_DIVISOR, O_DATA;

  int n_vec = 0;
  int n_err = 0;

  // Reference model of one row
  logic [D_W-1:0] stim    [ROW_LEN];
  int             exp_elem[ROW_LEN];
  logic [D_W-1:0] exp_out [ROW_LEN];
  int             exp_sum;
  logic           exp_sat;

  // Divider model state
  logic [31:0]    div_log [$];
  int             div_unstable = 0;
  logic           div_busy = 1'b0;
  int             div_cnt = 0;
  logic [D_W-1:0] div_a, div_b;

  softmax_norm_ctrl #(.D_W(D_W), .ROW_LEN(ROW_LEN), .DIV_TIMEOUT(64)) dut (
    .I_CLK          (I_CLK),
    .I_RST_N        (I_RST_N),
    .I_VLD          (I_VLD),
    .I_DATA         (I_DATA),
    .O_RDY          (O_RDY),
    .O_DIV_START    (O_DIV_START),
    .O_DIVIDEND     (O_DIVIDEND),
    .O_DIVISOR      (O_DIVISOR),
    .I_DIV_QUOTIENT (I_DIV_QUOTIENT),
    .I_DIV_OUT_VLD  (I_DIV_OUT_VLD),
    .O_VLD          (O_VLD),
    .O_DATA         (O_DATA),
    .O_LAST         (O_LAST),
    .I_RDY          (I_RDY),
    .O_SAT          (O_SAT),
    .O_ERR          (O_ERR)
  );

  always #5 I_CLK = ~I_CLK;

  function automatic logic [D_W-1:0] div_q(input int a, input int b);
    if (b == 0) return '1;
    return D_W'((a * (1 << Q_FRAC)) / b);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Row-level expectation: clamp, sum, saturate, divide.
  task automatic model_row();
    int s = 0;
    for (int i = 0; i < ROW_LEN; i++) begin
      exp_elem[i] = stim[i][D_W-1] ? 0 : int'(stim[i]);
      s += exp_elem[i];
    end
    exp_sat = (s > POS_MAX);
    exp_sum = exp_sat ? POS_MAX : s;
    for (int i = 0; i < ROW_LEN; i++) begin
      exp_out[i] = (exp_sum == 0) ? '0 : div_q(exp_elem[i], exp_sum);
    end
  endtask

  // Divider: latches operands on start, answers after DIV_LAT cycles, abandons on start drop.
  initial begin : divider_model
    forever begin
      @(negedge I_CLK);
      I_DIV_OUT_VLD = 1'b0;
      if (!div_busy) begin
        if (O_DIV_START) begin
          div_busy = 1'b1;
          div_cnt  = 0;
          div_a    = O_DIVIDEND;
          div_b    = O_DIVISOR;
          div_log.push_back({div_a, div_b});
        end
      end else if (!O_DIV_START) begin
        div_busy = 1'b0;
      end else begin
        if (O_DIVIDEND !== div_a || O_DIVISOR !== div_b) div_unstable++;
        div_cnt++;
        if (div_cnt >= DIV_LAT) begin
          I_DIV_OUT_VLD  = 1'b1;
          I_DIV_QUOTIENT = div_q(int'(div_a), int'(div_b));
          div_busy       = 1'b0;
        end
      end
    end
  end

  task automatic load_row();
    int i = 0;
    int guard = 0;
    div_log.delete();
    div_unstable = 0;
    model_row();
    while (i < ROW_LEN && guard < 200) begin
      @(negedge I_CLK);
      guard++;
      if ($urandom_range(0, 3) == 0) begin
        I_VLD  = 1'b0;
        I_DATA = D_W'($urandom);
      end else begin
        I_VLD  = 1'b1;
        I_DATA = stim[i];
        if (O_RDY) i++;
      end
    end
    chk("load_accepts", i, ROW_LEN);
    @(negedge I_CLK);
    I_VLD = 1'b0;
    chk("rdy_drop", O_RDY, 0);
    chk("sat_flag", O_SAT, exp_sat);
    chk("start_first", O_DIV_START, (exp_sum != 0));
  endtask

  task automatic drain_row(input bit hold);
    int k = 0;
    int guard = 0;
    int rises = 0;
    int overlap = 0;
    int rdy_bad = 0;
    int hold_left = hold ? 10 : 0;
    logic prev_start = 1'b0;
    logic holding = 1'b0;
    logic [31:0] held = '0;
    while (k < ROW_LEN && guard < 3000) begin
      @(negedge I_CLK);
      guard++;
      if (O_DIV_START && !prev_start) rises++;
      if (O_DIV_START && O_VLD) overlap++;
      if (O_RDY) rdy_bad++;
      prev_start = O_DIV_START;
      if (holding) chk("hold_stable", {O_VLD, O_LAST, O_DATA}, held);
      // Garbage on the input side must be ignored while the row is being processed.
      I_VLD  = 1'($urandom_range(0, 1));
      I_DATA = D_W'($urandom);
      holding = 1'b0;
      if (O_VLD) begin
        if (hold_left > 0) begin
          hold_left--;
          I_RDY = 1'b0;
        end else begin
          I_RDY = ($urandom_range(0, 2) != 0);
        end
        if (I_RDY) begin
          chk("out_data", O_DATA, exp_out[k]);
          chk("out_last", O_LAST, (k == ROW_LEN - 1));
          chk("out_sat", O_SAT, exp_sat);
          k++;
        end else begin
          holding = 1'b1;
          held    = {O_VLD, O_LAST, O_DATA};
        end
      end else begin
        I_RDY = 1'($urandom_range(0, 1));
      end
    end
    I_VLD = 1'b0;
    chk("out_count", k, ROW_LEN);
    chk("start_rises", rises, (exp_sum != 0) ? ROW_LEN : 0);
    chk("start_in_out", overlap, 0);
    chk("rdy_busy", rdy_bad, 0);
    chk("div_calls", div_log.size(), (exp_sum != 0) ? ROW_LEN : 0);
    for (int j = 0; j < div_log.size() && j < ROW_LEN; j++) begin
      chk("div_operands", div_log[j], {D_W'(exp_elem[j]), D_W'(exp_sum)});
    end
    chk("div_stable", div_unstable, 0);
    chk("err_low", O_ERR, 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rdy", O_RDY, 0);
    chk("rst_start", O_DIV_START, 0);
    chk("rst_dividend", O_DIVIDEND, 0);
    chk("rst_divisor", O_DIVISOR, 0);
    chk("rst_vld", O_VLD, 0);
    chk("rst_data", O_DATA, 0);
    chk("rst_last", O_LAST, 0);
    chk("rst_sat", O_SAT, 0);
    chk("rst_err", O_ERR, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stimulus
    logic [D_W-1:0] v;
    // Power-on reset
    repeat (2) @(negedge I_CLK);
    #1;
    chk_reset_outputs();
    @(negedge I_CLK);
    I_RST_N = 1'b1;
    chk("rdy_at_release", O_RDY, 0);
    @(negedge I_CLK);
    chk("rdy_rise", O_RDY, 1);

    // Uniform row: every output equals the input share
    for (int i = 0; i < ROW_LEN; i++) stim[i] = 16'h0400;
    load_row();
    drain_row(1'b0);

    // Single hot element
    for (int i = 0; i < ROW_LEN; i++) stim[i] = 16'h0000;
    stim[0] = 16'h2000;
    load_row();
    drain_row(1'b0);

    // All-zero row bypasses the divider
    for (int i = 0; i < ROW_LEN; i++) stim[i] = 16'h0000;
    load_row();
    drain_row(1'b0);

    // Saturating sum
    for (int i = 0; i < ROW_LEN; i++) stim[i] = 16'h2000;
    load_row();
    drain_row(1'b0);

    // Negative input clamped to zero, with a long backpressure hold on the first output
    for (int i = 0; i < ROW_LEN; i++) stim[i] = 16'h1000;
    stim[2] = 16'hF000;
    load_row();
    drain_row(1'b1);

    // Reset in the middle of a division
    for (int i = 0; i < ROW_LEN; i++) stim[i] = 16'h2000;
    load_row();
    repeat (10) @(negedge I_CLK);
    chk("pre_rst_start", O_DIV_START, 1);
    #2;
    I_RST_N = 1'b0;
    #1;
    chk_reset_outputs();
    @(negedge I_CLK);
    I_RST_N = 1'b1;
    chk("rdy_at_release2", O_RDY, 0);
    @(negedge I_CLK);
    chk("rdy_rise2", O_RDY, 1);

    // Random rows
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < ROW_LEN; i++) begin
        v = D_W'($urandom_range(0, 16'h1400));
        if ($urandom_range(0, 5) == 0) v = 16'h8000 | D_W'($urandom);
        if (r == 3) v = D_W'($urandom_range(16'h1000, 16'h7FFF));
        stim[i] = v;
      end
      load_row();
      drain_row(r == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
